cla_adder: RTL and testbench
============================

CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 Parameter ROBEN_W, default 5, width of the reorder-buffer entry tag carried alongside the operation.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 operand1  input  32  first operand, two's complement.
REQ-005 operand2  input  32  second operand, two's complement.
REQ-006 operation  input  1  0 = add (operand1 + operand2), 1 = subtract (operand1 - operand2).
REQ-007 ROBEN_in  input  ROBEN_W  tag of the issuing instruction.
REQ-008 valid_in  input  1  operands, operation and tag are valid this cycle.
REQ-009 result  output  32  registered sum or difference, low 32 bits.
REQ-010 ROBEN_out  output  ROBEN_W  registered copy of ROBEN_in for the same operation.
REQ-011 flow  output  1  registered signed-overflow flag for result.
REQ-012 valid_out  output  1  result, ROBEN_out and flow hold a completed operation.

Function
REQ-013 The datapath SHALL be a two-level carry-lookahead adder: eight 4-bit groups, each producing per-bit generate (a&b) and propagate (a^b) and group G/P, with a lookahead unit computing all group carries in parallel from carry-in; no ripple carry between groups.
REQ-014 Subtraction SHALL be done as operand1 + ~operand2 with carry-in 1; addition SHALL use operand2 unchanged with carry-in 0.
REQ-015 result SHALL equal (operand1 +/- operand2) mod 2^32; carry-out SHALL be discarded.
REQ-016 flow SHALL be 1 iff operand1[31] equals the effective second operand's bit 31 (operand2[31] for add, ~operand2[31] for subtract) and result[31] differs from operand1[31].
REQ-017 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on all outputs after edge N, held until the next edge.
REQ-018 valid_out SHALL equal valid_in registered; result, ROBEN_out and flow SHALL update every cycle regardless of valid_in.
REQ-019 There is no backpressure; a new operation SHALL be accepted every cycle, including back-to-back add/subtract with different tags.
REQ-020 ROBEN_out SHALL pass ROBEN_in unmodified, never affected by operands or operation.

Reset
REQ-021 While rst is high at a rising edge, result, ROBEN_out, flow and valid_out SHALL all be 0 after that edge, with inputs ignored.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight operation; the first operation sampled after rst deasserts SHALL appear one cycle later.

Configuration
REQ-023 Macro CLA_ADDER_FLOW_EN: when defined, flow SHALL be computed per REQ-016; when undefined, the overflow logic SHALL be omitted and flow SHALL be constant 0 (port retained).

Verification (CLA_ADDER_FLOW_EN defined)
REQ-024 Add 0x0AAAA34A + 0x00000014, ROBEN_in=4 -> next cycle result 0x0AAAA35E (178955102), flow 0, ROBEN_out 4.
REQ-025 Add 0x7FFFFFFF + 0x00000001, ROBEN_in=16 -> result 0x80000000, flow 1, ROBEN_out 16.
REQ-026 Subtract 0x00000052 - 0x00000341 -> result 0xFFFFFD11 (-751), flow 0; subtract 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, flow 1.
REQ-027 Subtract 0xF0000001 (-0x0FFFFFFF) - 0x0FFFFFFF -> result 0xE0000002, flow 0; add 0xFFFFFFF6 (-10) + 0x000000BC -> result 0x000000B2 (178), flow 0.
REQ-028 Back-to-back valid operations then rst high one cycle mid-stream -> each result one cycle after its input; after the reset edge all outputs 0, valid_out 0; operation after deassert appears one cycle later.
REQ-029 Build without CLA_ADDER_FLOW_EN, add 0x7FFFFFFF + 1 -> result 0x80000000, flow 0.

Source files
------------

// File: rtl/cla_adder.sv
// Registered 32-bit add/subtract: a two-level carry-lookahead adder with a one-cycle result.
// Define CLA_ADDER_FLOW_EN to produce the signed-overflow flag; otherwise flow is tied to 0.
module cla_adder #(
    parameter int unsigned ROBEN_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        operand1,
    input  logic [31:0]        operand2,
    input  logic               operation,
    input  logic [ROBEN_W-1:0] ROBEN_in,
    input  logic               valid_in,
    output logic [31:0]        result,
    output logic [ROBEN_W-1:0] ROBEN_out,
    output logic               flow,
    output logic               valid_out
);

    // Carries into each of the four bits of a group, from the group's carry-in.
    function automatic logic [3:0] group_carries(input logic [3:0] g, input logic [3:0] p,
                                                 input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [31:0] b_eff;
    logic        carry_in;
    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_c;
    logic [31:0] bit_c;
    logic [31:0] sum;
    logic        flow_d;

    assign b_eff    = operation ? ~operand2 : operand2;
    assign carry_in = operation;
    assign bit_g    = operand1 & b_eff;
    assign bit_p    = operand1 ^ b_eff;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 8; k++) begin
            grp_g[k] = bit_g[4*k+3]
                     | (bit_p[4*k+3] & bit_g[4*k+2])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
            grp_p[k] = &bit_p[4*k +: 4];
        end
    end

    // Each group carry is a flat sum of products over lower groups, so no group waits on another.
    always_comb begin
        grp_c = '0;
        for (int k = 0; k < 8; k++) begin
            logic term;
            term = carry_in;
            for (int m = 0; m < k; m++) begin
                term = term & grp_p[m];
            end
            grp_c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & grp_p[m];
                end
                grp_c[k] = grp_c[k] | term;
            end
        end
    end

    always_comb begin
        bit_c = '0;
        for (int k = 0; k < 8; k++) begin
            bit_c[4*k +: 4] = group_carries(bit_g[4*k +: 4], bit_p[4*k +: 4], grp_c[k]);
        end
    end

    assign sum = bit_p ^ bit_c;

`ifdef CLA_ADDER_FLOW_EN
    assign flow_d = ~(operand1[31] ^ b_eff[31]) & (sum[31] ^ operand1[31]);
`else
    assign flow_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            ROBEN_out <= '0;
            flow      <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            result    <= sum;
            ROBEN_out <= ROBEN_in;
            flow      <= flow_d;
            valid_out <= valid_in;
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Directed-vector bench for cla_adder; expected flow follows CLA_ADDER_FLOW_EN.
module tb_cla_adder;

    localparam int unsigned RobenW = 5;
`ifdef CLA_ADDER_FLOW_EN
    localparam bit FlowEn = 1'b1;
`else
    localparam bit FlowEn = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [31:0]       operand1;
    logic [31:0]       operand2;
    logic              operation;
    logic [RobenW-1:0] ROBEN_in;
    logic              valid_in;
    logic [31:0]       result;
    logic [RobenW-1:0] ROBEN_out;
    logic              flow;
    logic              valid_out;

    int checks;
    int errors;

    cla_adder #(.ROBEN_W(RobenW)) dut (
        .clk       (clk),
        .rst       (rst),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .ROBEN_in  (ROBEN_in),
        .valid_in  (valid_in),
        .result    (result),
        .ROBEN_out (ROBEN_out),
        .flow      (flow),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one operation, clock it in, and check every output one cycle later.
    task automatic apply(input string tag, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [RobenW-1:0] tg, input logic v,
                         input logic [31:0] exp_res, input logic exp_flow);
        operation = op;
        operand1  = a;
        operand2  = b;
        ROBEN_in  = tg;
        valid_in  = v;
        @(posedge clk);
        #1;
        check({tag, ".result"}, result, exp_res);
        check({tag, ".flow"}, {31'd0, flow}, {31'd0, exp_flow & FlowEn});
        check({tag, ".roben"}, {27'd0, ROBEN_out}, {27'd0, tg});
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".result"}, result, 32'h0);
        check({tag, ".flow"}, {31'd0, flow}, 32'h0);
        check({tag, ".roben"}, {27'd0, ROBEN_out}, 32'h0);
        check({tag, ".valid"}, {31'd0, valid_out}, 32'h0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        operation = 1'b0;
        operand1  = 32'h7FFF_FFFF;
        operand2  = 32'h0000_0001;
        ROBEN_in  = 5'd31;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst = 1'b0;

        apply("add_basic",  1'b0, 32'h0AAA_A34A, 32'h0000_0014, 5'd4,  1'b1, 32'h0AAA_A35E, 1'b0);
        apply("add_ovf",    1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd16, 1'b1, 32'h8000_0000, 1'b1);
        apply("sub_neg",    1'b1, 32'h0000_0052, 32'h0000_0341, 5'd3,  1'b1, 32'hFFFF_FD11, 1'b0);
        apply("sub_ovf",    1'b1, 32'h8000_0000, 32'h0000_0001, 5'd7,  1'b1, 32'h7FFF_FFFF, 1'b1);
        apply("sub_negneg", 1'b1, 32'hF000_0001, 32'h0FFF_FFFF, 5'd9,  1'b1, 32'hE000_0002, 1'b0);
        apply("add_mixed",  1'b0, 32'hFFFF_FFF6, 32'h0000_00BC, 5'd21, 1'b1, 32'h0000_00B2, 1'b0);
        apply("add_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd30, 1'b1, 32'h0000_0000, 1'b0);
        apply("sub_minint", 1'b1, 32'h0000_0000, 32'h8000_0000, 5'd1,  1'b1, 32'h8000_0000, 1'b1);
        apply("add_negovf", 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd2,  1'b1, 32'h0000_0000, 1'b1);
        apply("add_carry",  1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b1, 32'hACF1_3568, 1'b0);
        apply("sub_self",   1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd5,  1'b1, 32'h0000_0000, 1'b0);
        apply("invalid",    1'b0, 32'h0000_0F0F, 32'h0000_F0F0, 5'd11, 1'b0, 32'h0000_FFFF, 1'b0);

        // Mid-stream reset: the operation presented with rst must be dropped.
        apply("pre_rst",    1'b0, 32'h0000_0010, 32'h0000_0020, 5'd6,  1'b1, 32'h0000_0030, 1'b0);
        rst       = 1'b1;
        operation = 1'b0;
        operand1  = 32'h7FFF_FFFF;
        operand2  = 32'h7FFF_FFFF;
        ROBEN_in  = 5'd27;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        check_zero("mid_rst");
        rst = 1'b0;
        apply("post_rst",   1'b1, 32'h0000_0100, 32'h0000_0001, 5'd19, 1'b1, 32'h0000_00FF, 1'b0);
        apply("post_rst2",  1'b0, 32'h4000_0000, 32'h4000_0000, 5'd8,  1'b1, 32'h8000_0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
